// File: rtl/isa_pkg.sv
// isa_pkg: ISA definitions shared by the instruction decoder and instr_encoder.
//   - opcode constants
//   - bit positions of the common instruction fields
//   - encoder rejection codes
//   - helper that tests whether an immediate fits in a signed 6-bit field
package isa_pkg;

   localparam logic [3:0] OP_ADI  = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_NDU  = 4'b0010;
   localparam logic [3:0] OP_LHI  = 4'b0011;
   localparam logic [3:0] OP_LW   = 4'b0100;
   localparam logic [3:0] OP_SW   = 4'b0101;
   localparam logic [3:0] OP_RSV6 = 4'b0110;
   localparam logic [3:0] OP_RSV7 = 4'b0111;
   localparam logic [3:0] OP_BEQ  = 4'b1000;
   localparam logic [3:0] OP_JAL  = 4'b1001;
   localparam logic [3:0] OP_JLR  = 4'b1010;
   localparam logic [3:0] OP_JRI  = 4'b1011;
   localparam logic [3:0] OP_LM   = 4'b1100;
   localparam logic [3:0] OP_SM   = 4'b1101;
   localparam logic [3:0] OP_RA14 = 4'b1110;
   localparam logic [3:0] OP_RA15 = 4'b1111;

   // LSB positions of the common fields (opcode is 4 bits, registers and func 2 bits)
   localparam int F_OP_LSB   = 12;
   localparam int F_RA_LSB   = 10;
   localparam int F_RB_LSB   = 8;
   localparam int F_RC_LSB   = 6;
   localparam int F_FUNC_LSB = 0;

   typedef enum logic [2:0] {
      ERR_NONE   = 3'd0,
      ERR_OPCODE = 3'd1,
      ERR_REG    = 3'd2,
      ERR_IMM    = 3'd3
   } err_e;

   // A sign-extended immediate fits 6 bits when bits [15:6] all copy bit 5.
   function automatic logic imm_fits_s6(input logic [15:0] imm);
      return imm[15:6] == {10{imm[5]}};
   endfunction

endpackage

// File: rtl/instr_fifo2.sv
// instr_fifo2: 2-entry FIFO with valid/ready on both sides.
//   clk, rst_n            clock, asynchronous active-low reset (empties, zeroes storage)
//   in_valid/in_ready     write side; in_ready depends only on the count register
//   in_data [W-1:0]       word to store
//   out_valid/out_ready   read side; head is popped on out_valid & out_ready
//   out_data [W-1:0]      head entry, stable until popped
module instr_fifo2 #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic [1:0][W-1:0] mem;
   logic              wr_ptr, rd_ptr;
   logic [1:0]        count;
   logic              push, pop;

   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign out_data  = mem[rd_ptr];
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem    <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         // simultaneous push and pop leaves the count unchanged
         if (push && !pop)
            count <= count + 2'd1;
         else if (pop && !push)
            count <= count - 2'd1;
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into 16-bit instruction words.
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          field-bundle handshake (in_ready = buffer not full)
//   opcode, func, reg_ra/rb/rc, imm_data_se, reg_select_word, addr_offset
//                              decoded fields of one instruction
//   base_addr_load, base_addr  reload the address counter
//   out_valid/out_ready        packed-word handshake from the 2-entry buffer
//   out_instr, out_addr        packed word and its instruction-memory address
//   err_valid, err_code,       one-cycle rejection pulse, last reason,
//   err_count                  saturating rejection count
module instr_encoder
   import isa_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0]           opcode,
   input  logic [1:0]           func,
   input  logic [2:0]           reg_ra,
   input  logic [2:0]           reg_rb,
   input  logic [2:0]           reg_rc,
   input  logic [15:0]          imm_data_se,
   input  logic [7:0]           reg_select_word,
   input  logic [15:0]          addr_offset,
   input  logic                 base_addr_load,
   input  logic [ADDR_W-1:0]    base_addr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [15:0]          out_instr,
   output logic [ADDR_W-1:0]    out_addr,
   output logic                 err_valid,
   output logic [2:0]           err_code,
   output logic [ERR_CNT_W-1:0] err_count
);

   logic [15:0]       word;
   err_e              err;
   logic              use_rb, use_rc, imm_bad, reg_bad;
   logic              accept, push;
   logic [ADDR_W-1:0] addr_cnt, push_addr;

   // Pack fields and classify the bundle; only fields the opcode uses are checked.
   always_comb begin
      word    = '0;
      use_rb  = 1'b0;
      use_rc  = 1'b0;
      imm_bad = 1'b0;
      word[F_OP_LSB +: 4] = opcode;
      word[F_RA_LSB +: 2] = reg_ra[1:0];
      case (opcode)
         OP_ADI, OP_LW, OP_SW: begin
            use_rb              = 1'b1;
            word[F_RB_LSB +: 2] = reg_rb[1:0];
            word[5:0]           = imm_data_se[5:0];
            imm_bad             = !imm_fits_s6(imm_data_se);
         end
         OP_ADD, OP_NDU: begin
            use_rb                = 1'b1;
            use_rc                = 1'b1;
            word[F_RB_LSB +: 2]   = reg_rb[1:0];
            word[F_RC_LSB +: 2]   = reg_rc[1:0];
            word[F_FUNC_LSB +: 2] = func;
         end
         OP_LHI: begin
            // left-aligned immediate: only the upper 9 bits are encodable
            word[8:0] = imm_data_se[15:7];
            imm_bad   = |imm_data_se[6:0];
         end
         OP_LM, OP_SM: word[7:0] = reg_select_word;
         OP_BEQ: begin
            use_rb              = 1'b1;
            word[F_RB_LSB +: 2] = reg_rb[1:0];
            word[5:0]           = addr_offset[5:0];
            imm_bad             = |addr_offset[15:6];
         end
         OP_JAL, OP_JRI: begin
            word[8:0] = addr_offset[8:0];
            imm_bad   = |addr_offset[15:9];
         end
         OP_JLR: begin
            use_rb              = 1'b1;
            word[F_RB_LSB +: 2] = reg_rb[1:0];
         end
         default: ;
      endcase
      reg_bad = reg_ra[2] | (use_rb & reg_rb[2]) | (use_rc & reg_rc[2]);
      if (opcode == OP_RSV6 || opcode == OP_RSV7) err = ERR_OPCODE;
      else if (reg_bad)                           err = ERR_REG;
      else if (imm_bad)                           err = ERR_IMM;
      else                                        err = ERR_NONE;
   end

   assign accept    = in_valid & in_ready;
   assign push      = accept & (err == ERR_NONE);
   // a load in the same cycle as a push gives that word the new base
   assign push_addr = base_addr_load ? base_addr : addr_cnt;

   instr_fifo2 #(.W(16 + ADDR_W)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (push),
      .in_ready  (in_ready),
      .in_data   ({word, push_addr}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  ({out_instr, out_addr})
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_cnt  <= '0;
         err_valid <= 1'b0;
         err_code  <= ERR_NONE;
         err_count <= '0;
      end else begin
         if (push)
            addr_cnt <= push_addr + ADDR_W'(1);
         else if (base_addr_load)
            addr_cnt <= base_addr;
         err_valid <= accept & (err != ERR_NONE);
         if (accept && err != ERR_NONE) begin
            err_code <= err;
            if (err_count != '1)
               err_count <= err_count + ERR_CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Packs decoded instruction fields back into 16-bit instruction words. It is the inverse of the pipeline's instruction decoder and uses the same field layout. It sits between the program-loader / test-stimulus front end and instruction memory:
- accepts one field bundle per handshake;
- range-checks every field and rejects bundles that cannot be encoded;
- emits packed words with their target memory addresses through a 2-entry output buffer, giving full throughput under backpressure.

## Interface
Parameters:
- ADDR_W, 16, width of the instruction-memory address counter
- ERR_CNT_W, 8, width of the saturating error counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  bundle accepted when in_valid & in_ready at clk edge
- opcode  in  4  instruction opcode
- func  in  2  ALU function (ADD/NDU group)
- reg_ra, reg_rb, reg_rc  in  3 each  register indices
- imm_data_se  in  16  sign-extended immediate (ADI/LW/SW); left-aligned immediate (LHI)
- reg_select_word  in  8  LM/SM register mask
- addr_offset  in  16  zero-extended branch/jump offset
- base_addr_load  in  1  load base_addr into the address counter
- base_addr  in  ADDR_W  new start address
- out_valid  out  1  out_instr/out_addr valid
- out_ready  in  1  consumer accepts head word
- out_instr  out  16  packed instruction
- out_addr  out  ADDR_W  memory address for out_instr
- err_valid  out  1  one-cycle pulse: accepted bundle rejected
- err_code  out  3  reason, held until the next rejection
- err_count  out  ERR_CNT_W  saturating count of rejections

## Operation
- Common field packing: [15:12] opcode, [11:10] ra[1:0], [9:8] rb[1:0], [7:6] rc[1:0], [1:0] func.
- All unused bits are zero.
- Per-opcode packing:
  - 0000 ADI, 0100 LW, 0101 SW: ra, rb, [5:0] imm[5:0].
  - 0001, 0010: ra, rb, rc, func.
  - 0011 LHI: ra, [8:0] imm[15:7].
  - 1100 LM, 1101 SM: ra, [7:0] reg_select_word.
  - 1110, 1111: ra only.
  - 1000 BEQ: ra, rb, [5:0] offset[5:0].
  - 1001 JAL, 1011 JRI: ra, [8:0] offset[8:0].
  - 1010 JLR: ra, rb.
- Rejection checks, highest priority first, applied only to the fields the opcode uses:
  - err 1: opcode 0110 or 0111.
  - err 2: any used register index > 3.
  - err 3: immediate or offset not representable:
    - ADI/LW/SW: imm[15:6] is not all equal to imm[5].
    - LHI: imm[6:0] is nonzero.
    - BEQ: offset[15:6] is nonzero.
    - JAL/JRI: offset[15:9] is nonzero.
- Rejected bundles are consumed:
  - in_ready behaves normally;
  - nothing is pushed and the address counter does not advance;
  - err_valid pulses for one cycle; err_code is updated;
  - err_count increments and saturates at all-ones.
- Address counter:
  - Each pushed word takes the current counter value, then the counter increments.
  - Wraps from all-ones to 0.
- base_addr_load:
  - Sets the counter to base_addr.
  - If a push occurs in the same cycle, the pushed word gets base_addr and the counter becomes base_addr+1.
  - Words already buffered keep their addresses.
- Buffer: 2-entry FIFO of {instr, addr}. Words leave in acceptance order.

## Timing
- in_ready = (buffer count != 2), combinational from the count register. No dependence on out_ready.
- Latency: a bundle accepted at edge N appears on out_instr with out_valid=1 after edge N (visible in cycle N+1).
- Pop occurs when out_valid & out_ready.
- Push and pop in the same cycle: count unchanged. Ordering is preserved.
- With out_ready held high: one word per cycle sustained.
- out_instr and out_addr are stable while out_valid=1 and out_ready=0.
- err_valid is registered and asserts in cycle N+1 for a bundle accepted at edge N.
- Reset (asynchronous, any time, including mid-transfer):
  - Buffer is emptied; out_valid=0; out_instr=0; out_addr=0.
  - Address counter=0.
  - err_valid=0; err_code=0; err_count=0.
  - Buffered words are discarded.
  - Inputs are ignored while rst_n=0.

## Structure
- Shared package isa_pkg holds:
  - opcode constants (OP_ADI … OP_JRI);
  - field bit positions;
  - err code constants (ERR_NONE=0, ERR_OPCODE=1, ERR_REG=2, ERR_IMM=3).
- The decoder and this block both use isa_pkg.
- One sub-module: instr_fifo2, a parameterised 2-entry FIFO with valid/ready on both sides.
- Packing, checks, address counter and error logic live in instr_encoder.

## Test plan
- ADD: opcode=0001, ra=1, rb=2, rc=3, func=00 → out_instr=16'h16C0, out_addr=0, one cycle after acceptance.
- ADI: ra=0, rb=1, imm=16'hFFFF → 16'h013F. LHI ra=2, imm=16'hFF80 → 16'h39FF.
- Rejections, none of which produce output:
  - LHI imm=16'h0081 → err_code=3.
  - opcode=0110 → err_code=1.
  - ADD with rc=5 → err_code=2.
  - After these three: err_count=3 and address counter unchanged.
- Backpressure:
  - out_ready=0, three back-to-back valid bundles → first two accepted, then in_ready=0 and the third is held.
  - Raise out_ready → words emitted in order at addresses 0, 1, 2, one per cycle.
- Wrap and load:
  - base_addr_load with base_addr=16'hFFFF, then two bundles → out_addr 16'hFFFF then 16'h0000.
  - base_addr_load coincident with a push → that word gets base_addr.
- Reset mid-operation: assert rst_n=0 with 2 words buffered → out_valid=0, in_ready=1 and err_count=0 immediately, no clock edge needed.
